nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that performs a WIDTH-bit add/subtract by running one 4-bit ripple
//  slice over the operands, one nibble per clock, least-significant nibble first.
//  It is the area-saving alternative to a full-width adder in the MIPS ALU path.
//  It uses a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBS   WIDTH/4 (localparam)  number of RUN cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operands a/b/cin/sub are valid
//  in_ready   out  1      block can accept operands (state IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (add only)
//  sub        in   1      1 = compute a-b (see CONFIGURATION)
//  out_valid  out  1      sum/cout/overflow are valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of the MSB (for sub: 1 = no borrow)
//  overflow   out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset: one clock, synchronous, active low (rst_n=0 sampled on clk edge).
//    It sets state=IDLE, out_valid=0, sum=0, cout=0, overflow=0, carry and
//    nibble counter to 0. Reset wins over every other event, including mid-RUN.
//  - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE), combinational.
//  - IDLE: when in_valid is high, latch a, y = sub_eff ? ~b : b, and
//    carry = sub_eff ? 1 : cin. Clear cnt. Go to RUN.
//  - RUN: each cycle adds the low nibbles of a_sh and y_sh plus carry in the slice.
//    Shift a_sh and y_sh right by 4. Shift the slice result into the top of
//    res_sh ({s4, res_sh[W-1:4]}). carry <= slice carry out. cnt++.
//  - Last nibble (cnt==NIBS-1): capture cout = slice carry out.
//    Capture overflow = (x[3]==y[3]) && (s[3]!=x[3]) using the slice bits.
//    Load sum <= final res_sh. Go to DONE.
//  - DONE: out_valid=1. sum, cout and overflow stay stable until out_ready=1.
//    On out_ready go to IDLE next cycle. No same-cycle re-accept; peak throughput
//    is one op per NIBS+2 cycles.
//  - Latency: out_valid rises exactly NIBS clocks after the accepting edge (8 for WIDTH=32).
//  - in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
//  - sum, cout and overflow hold their last result until the next last-nibble write.
//  - Arithmetic is modulo 2^WIDTH. The carry reg is 1 bit. cnt is $clog2(NIBS) bits and
//    wraps to 0 on the IDLE accept only.
// CONFIGURATION
//  SUB_EN defined: sub_eff = sub. Subtraction is a + ~b + 1, and cin is ignored when sub=1.
//  SUB_EN undefined: sub_eff = 0. The sub port is still present but ignored,
//    so the block is add-only (a + b + cin). The port list is the same in both builds.
// STRUCTURE
//  - Shared header adder_defs.vh holds NIB_W=4 and the FSM encodings
//    ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - One sub-module: nibble_add4, the 4-bit ripple slice with ports
//    (cin, x[3:0], y[3:0], s[3:0], cout). It exposes s[3] for the overflow check.
//  - Everything else (FSM, shifters, counter, result regs) is inline in this module.
// TESTING
//  1 Reset: rst_n=0 for 2 clks -> out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 after release.
//  2 Add 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0;
//    out_valid exactly 8 clks after accept; in_ready=0 throughout.
//  3 Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, overflow=1;
//    also 0x12345678 + 0x11111111, cin=1 -> 0x2345678A.
//  4 sub=1, a=5, b=7: with SUB_EN -> sum=0xFFFFFFFE, cout=0, overflow=0;
//    without SUB_EN -> sum=0x0000000C.
//  5 Backpressure: hold out_ready=0 for 5 clks in DONE -> out_valid, sum and flags stable;
//    an in_valid pulse during RUN/DONE is not accepted; the next op completes correctly.
//  6 Reset mid-op: rst_n=0 at RUN cnt=3 -> IDLE next clk; out_valid never rises;
//    then 3+4 -> sum=7, cout=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width and FSM encodings.
package nibble_serial_add_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// nibble_add4: 4-bit ripple-carry slice reused once per clock by the serial sequencer.
module nibble_add4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic             cin,
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    always_comb begin
        c[0] = cin;
        s    = '0;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add (and, with SUB_EN defined, subtract) computed one nibble per clock, LSB first.
// Build option: define SUB_EN to honour the sub input; otherwise the block is add-only.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for operands
// RUN     | one nibble per clock through the slice, NIBS cycles
// DONE    | out_valid=1, result held until out_ready
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, y_sh, res_sh, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sub_eff;
    logic [NIB_W-1:0] s4;
    logic             c4;
    logic             last_nib;

`ifdef SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    nibble_add4 u_slice (
        .cin  (carry),
        .x    (a_sh[NIB_W-1:0]),
        .y    (y_sh[NIB_W-1:0]),
        .s    (s4),
        .cout (c4)
    );

    assign res_nxt   = {s4, res_sh[WIDTH-1:NIB_W]};
    assign last_nib  = (cnt == LAST);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_nib)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            y_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                a_sh  <= a;
                y_sh  <= sub_eff ? ~b : b;
                carry <= sub_eff ? 1'b1 : cin;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                a_sh   <= a_sh >> NIB_W;
                y_sh   <= y_sh >> NIB_W;
                res_sh <= res_nxt;
                carry  <= c4;
                cnt    <= cnt + 1'b1;
                if (last_nib) begin
                    // top nibble of the operands carries the sign bits
                    sum      <= res_nxt;
                    cout     <= c4;
                    overflow <= (a_sh[3] == y_sh[3]) && (s4[3] != a_sh[3]);
                end
            end
        end
    end

endmodule
